// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA channel sequencer and its arbiter.
package dma_seq_pkg;

  // Width of the per-channel register storage; the top-level ADDR_W/CNT_W track these
  localparam int SEQ_ADDR_W = 16;
  localparam int SEQ_CNT_W  = 16;

  // One-hot sequencer states; 6'b010000 (S3) is reserved and never entered
  typedef enum logic [5:0] {
    ST_SI = 6'b000001,
    ST_S0 = 6'b000010,
    ST_S1 = 6'b000100,
    ST_S2 = 6'b001000,
    ST_S4 = 6'b100000
  } seq_state_t;

  // Per-channel transfer mode; the fourth encoding behaves like single
  typedef enum logic [1:0] {
    MODE_DEMAND     = 2'b00,
    MODE_SINGLE     = 2'b01,
    MODE_BLOCK      = 2'b10,
    MODE_ALT_SINGLE = 2'b11
  } mode_t;

  localparam logic PRIO_FIXED    = 1'b0;
  localparam logic PRIO_ROTATING = 1'b1;

  typedef struct packed {
    logic [SEQ_ADDR_W-1:0] base_addr;
    logic [SEQ_ADDR_W-1:0] cur_addr;
    logic [SEQ_CNT_W-1:0]  base_count;
    logic [SEQ_CNT_W-1:0]  cur_count;
  } ch_regs_t;

endpackage

// File: rtl/dma_priority_arbiter.sv
// Combinational fixed/rotating priority arbiter over the eligible request vector.
module dma_priority_arbiter
  import dma_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              prio_type,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  // Scan circularly from the highest-priority slot; the first requester found wins
  always_comb begin
    int start;
    int idx;
    grant = '0;
    valid = 1'b0;
    start = (prio_type == PRIO_ROTATING) ? int'(ptr) : 0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!valid && req[idx]) begin
        grant = IDX_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_sequencer.sv
// 8237-style DMA channel sequencer: arbitration, HRQ/HLDA handshake and per-word commit.
// Register storage is sized by dma_seq_pkg; keep ADDR_W/CNT_W equal to SEQ_ADDR_W/SEQ_CNT_W.
module dma_channel_sequencer
  import dma_seq_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = SEQ_ADDR_W,
  parameter  int CNT_W  = SEQ_CNT_W,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic                HLDA,
  input  logic                EOP_N,
  input  logic                priorityType,
  input  logic [NUM_CH-1:0]   chMask,
  input  logic [2*NUM_CH-1:0] modeSelect,
  input  logic [NUM_CH-1:0]   addrDec,
  input  logic [NUM_CH-1:0]   autoInit,
  input  logic                ldValid,
  input  logic [IDX_W-1:0]    ldCh,
  input  logic [ADDR_W-1:0]   ldAddr,
  input  logic [CNT_W-1:0]    ldCount,
  output logic                ldReady,
  output logic                HRQ,
  output logic                AEN,
  output logic                ADSTB,
  output logic [ADDR_W-1:0]   ADDR,
  output logic [NUM_CH-1:0]   DACK,
  output logic                XFER,
  output logic                EOP_OUT_N,
  output logic [NUM_CH-1:0]   tcStatus,
  output logic [5:0]          state
);

  seq_state_t         state_q, state_d;
  ch_regs_t           regs [NUM_CH];
  logic [IDX_W-1:0]   active_ch, prio_ptr, arb_grant;
  logic               arb_valid;
  logic [NUM_CH-1:0]  done, eligible;
  mode_t              active_mode;
  logic               active_tc, commit_end;
  logic [ADDR_W-1:0]  next_addr;

  assign eligible    = DREQ & ~chMask & ~done;
  assign active_mode = mode_t'(modeSelect[2*int'(active_ch) +: 2]);
  assign active_tc   = (regs[active_ch].cur_count == '0);
  assign commit_end  = active_tc || !EOP_N;
  assign next_addr   = addrDec[active_ch] ? regs[active_ch].cur_addr - ADDR_W'(1)
                                          : regs[active_ch].cur_addr + ADDR_W'(1);
  assign state       = state_q;

  dma_priority_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .req       (eligible),
    .ptr       (prio_ptr),
    .prio_type (priorityType),
    .grant     (arb_grant),
    .valid     (arb_valid)
  );

  // Sequencer state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_SI;
    else          state_q <= state_d;
  end

  // Next-state selection and bus output decode from the registered state
  always_comb begin
    state_d   = state_q;
    ldReady   = (state_q == ST_SI);
    HRQ       = (state_q != ST_SI);
    AEN       = (state_q == ST_S1) || (state_q == ST_S2) || (state_q == ST_S4);
    ADSTB     = (state_q == ST_S1);
    XFER      = (state_q == ST_S2) || (state_q == ST_S4);
    DACK      = XFER ? (NUM_CH'(1) << active_ch) : '0;
    ADDR      = AEN ? regs[active_ch].cur_addr : '0;
    EOP_OUT_N = !((state_q == ST_S4) && active_tc);
    case (state_q)
      ST_SI: if (|eligible) state_d = ST_S0;
      ST_S0: begin
        if (!arb_valid || !EOP_N) state_d = ST_SI;
        else if (HLDA)            state_d = ST_S1;
      end
      ST_S1: state_d = HLDA ? ST_S2 : ST_SI;
      ST_S2: state_d = HLDA ? ST_S4 : ST_SI;
      ST_S4: begin
        if (commit_end) state_d = ST_SI;
        else begin
          case (active_mode)
            MODE_BLOCK:  state_d = ST_S1;
            MODE_DEMAND: state_d = DREQ[active_ch] ? ST_S1 : ST_SI;
            default:     state_d = ST_SI;
          endcase
        end
      end
      default: state_d = ST_SI;
    endcase
  end

  // Channel registers, done/TC flags, active channel latch and rotation pointer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
      done      <= '0;
      tcStatus  <= '0;
      active_ch <= '0;
      prio_ptr  <= '0;
    end else begin
      case (state_q)
        ST_SI: begin
          if (ldValid) begin
            regs[ldCh]     <= '{base_addr: ldAddr, cur_addr: ldAddr,
                                base_count: ldCount, cur_count: ldCount};
            tcStatus[ldCh] <= 1'b0;
            done[ldCh]     <= 1'b0;
          end
        end
        ST_S0: begin
          if (HLDA && arb_valid && EOP_N) active_ch <= arb_grant;
        end
        ST_S4: begin
          regs[active_ch].cur_addr  <= next_addr;
          regs[active_ch].cur_count <= regs[active_ch].cur_count - CNT_W'(1);
          prio_ptr <= IDX_W'((int'(active_ch) + 1) % NUM_CH);
          if (commit_end) begin
            tcStatus[active_ch] <= 1'b1;
            if (autoInit[active_ch]) begin
              regs[active_ch].cur_addr  <= regs[active_ch].base_addr;
              regs[active_ch].cur_count <= regs[active_ch].base_count;
            end else begin
              done[active_ch] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Scoreboard bench: a transaction-level model predicts the committed word stream.
module tb_dma_channel_sequencer;

  localparam int NUM_CH = 4;
  localparam logic [5:0] S_SI = 6'b000001, S_S0 = 6'b000010, S_S1 = 6'b000100,
                         S_S2 = 6'b001000, S_S4 = 6'b100000;

  logic        CLK = 1'b0, RESET_N = 1'b0;
  logic [3:0]  DREQ = '0, chMask = '0, addrDec = '0, autoInit = '0;
  logic        HLDA = 1'b0, EOP_N = 1'b1, priorityType = 1'b0, ldValid = 1'b0;
  logic [7:0]  modeSelect = '0;
  logic [1:0]  ldCh = '0;
  logic [15:0] ldAddr = '0, ldCount = '0;
  logic        ldReady, HRQ, AEN, ADSTB, XFER, EOP_OUT_N;
  logic [15:0] ADDR;
  logic [3:0]  DACK, tcStatus;
  logic [5:0]  state;

  dma_channel_sequencer #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N(EOP_N),
    .priorityType(priorityType), .chMask(chMask), .modeSelect(modeSelect),
    .addrDec(addrDec), .autoInit(autoInit), .ldValid(ldValid), .ldCh(ldCh),
    .ldAddr(ldAddr), .ldCount(ldCount), .ldReady(ldReady), .HRQ(HRQ), .AEN(AEN),
    .ADSTB(ADSTB), .ADDR(ADDR), .DACK(DACK), .XFER(XFER), .EOP_OUT_N(EOP_OUT_N),
    .tcStatus(tcStatus), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          ch;
    logic [15:0] addr;
    bit          tc;
  } word_t;

  word_t       exp_q[$];
  word_t       mon_w;
  int          n_cmp = 0, n_bad = 0;
  bit          strict = 1'b1;

  logic [15:0] m_base_addr [4], m_addr [4], m_base_cnt [4], m_cnt [4];
  bit   [3:0]  m_done, m_tcs;
  int          m_ptr;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pop the next predicted word every time the DUT sits in the commit state
  always @(negedge CLK) begin
    if (RESET_N && state == S_S4) begin
      if (exp_q.size() == 0) begin
        if (strict) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_word: got DACK %b ADDR %h, expected no word", DACK, ADDR);
        end
      end else begin
        mon_w = exp_q.pop_front();
        check_output("word_dack", 32'(DACK), 32'(1) << mon_w.ch);
        check_output("word_addr", 32'(ADDR), 32'(mon_w.addr));
        check_output("word_eop_out_n", 32'(EOP_OUT_N), 32'(!mon_w.tc));
      end
    end
  end

  // Predict the word stream from the programmed channels and the held request pattern
  task automatic model_run(input int max_words);
    int words = 0;
    int win;
    int c;
    bit tc;
    bit stay;
    while (1) begin
      win = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = priorityType ? (m_ptr + k) % NUM_CH : k;
        if (win < 0 && DREQ[c] && !chMask[c] && !m_done[c]) win = c;
      end
      if (win < 0 || words >= max_words) break;
      stay = 1'b1;
      while (stay && words < max_words) begin
        tc = (m_cnt[win] == 16'd0);
        exp_q.push_back('{ch: win, addr: m_addr[win], tc: tc});
        words++;
        m_addr[win] = addrDec[win] ? m_addr[win] - 16'd1 : m_addr[win] + 16'd1;
        m_cnt[win]  = m_cnt[win] - 16'd1;
        m_ptr       = (win + 1) % NUM_CH;
        if (tc) begin
          m_tcs[win] = 1'b1;
          stay       = 1'b0;
          if (autoInit[win]) begin
            m_addr[win] = m_base_addr[win];
            m_cnt[win]  = m_base_cnt[win];
          end else begin
            m_done[win] = 1'b1;
          end
        end else begin
          case (modeSelect[2*win +: 2])
            2'b10:   stay = 1'b1;
            2'b00:   stay = DREQ[win];
            default: stay = 1'b0;
          endcase
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; DREQ = '0; HLDA = 1'b0; EOP_N = 1'b1; ldValid = 1'b0;
    chMask = '0; addrDec = '0; autoInit = '0; modeSelect = '0; priorityType = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      m_base_addr[i] = '0; m_addr[i] = '0; m_base_cnt[i] = '0; m_cnt[i] = '0;
    end
    m_done = '0; m_tcs = '0; m_ptr = 0;
    exp_q.delete();
    strict = 1'b1;
  endtask

  task automatic apply_stimulus(input int ch, input logic [15:0] a, input logic [15:0] c);
    @(negedge CLK);
    ldValid = 1'b1; ldCh = 2'(ch); ldAddr = a; ldCount = c;
    @(negedge CLK);
    ldValid = 1'b0;
    m_base_addr[ch] = a; m_addr[ch] = a; m_base_cnt[ch] = c; m_cnt[ch] = c;
    m_done[ch] = 1'b0; m_tcs[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < bound) begin
      @(posedge CLK);
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL %s_drain: got %0d words pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_phase(input string name);
    wait_drain(name, 2000);
    repeat (15) @(negedge CLK);
    check_output({name, "_idle_state"}, 32'(state), 32'(S_SI));
    check_output({name, "_tc_status"}, 32'(tcStatus), 32'(m_tcs));
  endtask

  task automatic wait_state(input string name, input logic [5:0] st);
    int cyc = 0;
    while (state != st && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    check_output({name, "_reached"}, 32'(state), 32'(st));
  endtask

  // Time limit in case the DUT never settles
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized phases
  initial begin
    repeat (2) @(negedge CLK);
    check_output("reset_state", 32'(state), 32'(S_SI));
    check_output("reset_bus", 32'({HRQ, AEN, ADSTB, XFER, DACK}), 32'(0));
    check_output("reset_addr", 32'(ADDR), 32'(0));
    check_output("reset_eop_ld", 32'({EOP_OUT_N, ldReady}), 32'(2'b11));
    check_output("reset_tc", 32'(tcStatus), 32'(0));
    RESET_N = 1'b1;

    // Block TC with handshake timing
    do_reset();
    apply_stimulus(0, 16'h0100, 16'd2);
    modeSelect = 8'b00_00_00_10; HLDA = 1'b0; DREQ = 4'b0001;
    model_run(100);
    #1 check_output("hrq_before", 32'(HRQ), 32'(0));
    @(posedge CLK); #1;
    check_output("hrq_after_req", 32'({HRQ, state}), 32'({1'b1, S_S0}));
    repeat (2) @(posedge CLK);
    #1 check_output("s0_wait_hlda", 32'(state), 32'(S_S0));
    @(negedge CLK); HLDA = 1'b1;
    @(posedge CLK); #1;
    check_output("s1_adstb", 32'({ADSTB, DACK}), 32'({1'b1, 4'b0000}));
    check_output("s1_addr", 32'(ADDR), 32'(16'h0100));
    @(posedge CLK); #1;
    check_output("s2_dack", 32'({XFER, ADSTB, DACK}), 32'({2'b10, 4'b0001}));
    @(posedge CLK); #1;
    check_output("s4_dack", 32'({state, DACK}), 32'({S_S4, 4'b0001}));
    finish_phase("block_tc");

    // Fixed priority
    do_reset();
    apply_stimulus(1, 16'h1111, 16'd0);
    apply_stimulus(2, 16'h2222, 16'd0);
    apply_stimulus(3, 16'h3333, 16'd0);
    modeSelect = 8'b01_01_01_01; HLDA = 1'b1; DREQ = 4'b1110;
    model_run(100);
    finish_phase("fixed_1110");
    do_reset();
    apply_stimulus(3, 16'h3000, 16'd1);
    modeSelect = 8'b01_01_01_01; HLDA = 1'b1; DREQ = 4'b1000;
    model_run(100);
    finish_phase("fixed_1000");

    // Rotating priority
    do_reset();
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(i, 16'(16'h0010 * i), 16'd1);
    modeSelect = 8'b01_01_01_01; priorityType = 1'b1; HLDA = 1'b1; DREQ = 4'b1111;
    model_run(100);
    finish_phase("rotating");

    // Auto-init with decrementing address: ch0 keeps being re-granted
    do_reset();
    apply_stimulus(0, 16'h0100, 16'd2);
    modeSelect = 8'b00_00_00_10; addrDec = 4'b0001; autoInit = 4'b0001;
    HLDA = 1'b1; DREQ = 4'b0001;
    model_run(6);
    wait_drain("autoinit", 500);
    strict = 1'b0;
    check_output("autoinit_tc", 32'(tcStatus), 32'(4'b0001));
    wait_state("autoinit_regrant", S_S4);

    // HLDA dropped in S1: no update, then the full block runs from the original values
    do_reset();
    apply_stimulus(0, 16'h0500, 16'd3);
    modeSelect = 8'b00_00_00_10; HLDA = 1'b0; DREQ = 4'b0001;
    model_run(100);
    wait_state("abort_s0", S_S0);
    HLDA = 1'b1;
    @(posedge CLK); #1 check_output("abort_s1", 32'(state), 32'(S_S1));
    @(negedge CLK); HLDA = 1'b0;
    @(posedge CLK); #1 check_output("abort_to_si", 32'(state), 32'(S_SI));
    repeat (3) @(negedge CLK);
    HLDA = 1'b1;
    finish_phase("abort_resume");

    // External EOP during a demand-mode commit
    do_reset();
    apply_stimulus(2, 16'h0A00, 16'd5);
    modeSelect = 8'b00_00_00_00; HLDA = 1'b1; DREQ = 4'b0100;
    exp_q.push_back('{ch: 2, addr: 16'h0A00, tc: 1'b0});
    m_tcs[2] = 1'b1; m_done[2] = 1'b1;
    wait_state("eop_s4", S_S4);
    EOP_N = 1'b0;
    @(posedge CLK); #1 check_output("eop_to_si", 32'({state, tcStatus}), 32'({S_SI, 4'b0100}));
    @(negedge CLK); EOP_N = 1'b1;
    finish_phase("eop_demand");

    // Asynchronous reset in the middle of a block word
    do_reset();
    apply_stimulus(0, 16'h0700, 16'd5);
    modeSelect = 8'b00_00_00_10; HLDA = 1'b1; DREQ = 4'b0001;
    wait_state("reset_mid_s2", S_S2);
    #2 RESET_N = 1'b0;
    #1;
    check_output("mid_reset_state", 32'(state), 32'(S_SI));
    check_output("mid_reset_bus", 32'({HRQ, DACK, EOP_OUT_N}), 32'({1'b0, 4'b0000, 1'b1}));
    @(negedge CLK); DREQ = '0; RESET_N = 1'b1;

    // Randomized phases against the transaction-level model
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int i = 0; i < NUM_CH; i++)
        apply_stimulus(i, 16'($urandom), 16'($urandom_range(0, 3)));
      modeSelect   = 8'($urandom);
      addrDec      = 4'($urandom);
      chMask       = 4'($urandom) & 4'($urandom);
      priorityType = 1'($urandom);
      HLDA         = 1'b1;
      DREQ         = 4'($urandom_range(1, 15));
      model_run(1000);
      finish_phase("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
